// File: rtl/fpdiv_ctrl_if.sv
// Handshake and datapath-control bundle between issue logic, the Goldschmidt
// divide datapath and the fpdiv_ctrl sequencer.
interface fpdiv_ctrl_if;
    logic        start;
    logic [31:0] final_ans;
    logic [1:0]  op_type;
    logic [1:0]  sel_mux3;
    logic [1:0]  sel_mux4;
    logic        en_a;
    logic        en_b;
    logic        en_rem;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  res_op;

    modport master (
        output start, final_ans, op_type,
        input  sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, done, result, res_op
    );

    modport slave (
        input  start, final_ans, op_type,
        output sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, done, result, res_op
    );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divide sequencer: initial multiply, ITERS refinement iterations,
// remainder multiply, then result capture. Outputs are registered state decode.
module fpdiv_ctrl #(
    parameter int ITERS = 3  // refinement iterations, 0..7
) (
    input  logic        clk,
    input  logic        reset,
    fpdiv_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, INIT_A, INIT_B, ITER_A, ITER_B, REM, CAPTURE, DONE
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] count;

    // {sel_mux3, sel_mux4, en_a, en_b, en_rem}
    function automatic logic [6:0] decode(input state_t s);
        case (s)
            INIT_A:  decode = {2'd0, 2'd0, 1'b1, 1'b0, 1'b0};
            INIT_B:  decode = {2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
            ITER_A:  decode = {2'd1, 2'd2, 1'b1, 1'b0, 1'b0};
            ITER_B:  decode = {2'd1, 2'd3, 1'b0, 1'b1, 1'b0};
            REM:     decode = {2'd2, 2'd2, 1'b0, 1'b0, 1'b1};
            default: decode = 7'd0;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? INIT_A : IDLE;
            INIT_A:  state_nxt = INIT_B;
            INIT_B:  state_nxt = (ITERS > 0) ? ITER_A : REM;
            ITER_A:  state_nxt = ITER_B;
            // count holds the number of ITER_B steps already completed
            ITER_B:  state_nxt = (int'(count) < ITERS - 1) ? ITER_A : REM;
            REM:     state_nxt = CAPTURE;
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = bus.start ? INIT_A : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are loaded from the next-state decode so they line up with the
    // state register and never depend combinationally on start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            bus.result <= '0;
            bus.res_op <= '0;
            {bus.sel_mux3, bus.sel_mux4, bus.en_a, bus.en_b, bus.en_rem} <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
        end else begin
            state <= state_nxt;
            {bus.sel_mux3, bus.sel_mux4, bus.en_a, bus.en_b, bus.en_rem} <= decode(state_nxt);
            bus.busy <= (state_nxt != IDLE) && (state_nxt != DONE);
            bus.done <= (state_nxt == DONE);
            if (state == INIT_A)
                count <= '0;
            else if (state == ITER_B)
                count <= count + 3'd1;
            if (state == CAPTURE) begin
                bus.result <= bus.final_ans;
                bus.res_op <= bus.op_type;
            end
        end
    end
endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
- Sequencer for the Goldschmidt floating-point divide datapath.
- The datapath consumes multiplier operand selects and register enables; this block generates them from a single start request.
- Steps performed: initial-approximation multiply, ITERS refinement iterations, remainder multiply, then result/rounding-mode capture.
- Sits between the issue logic and the divide datapath; owns the divide handshake (start/busy/done).

Parameters:
- ITERS, 3, number of refinement iterations after the initial step; legal range 0..7.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  divide request; sampled only in IDLE and DONE
- final_ans  input  32  packed result from datapath (sign, exp, mantissa)
- op_type  input  2  rounding op chosen by datapath: 0 = Q, 1 = QP, 2 = QM
- sel_mux3  output  2  multiplier operand A select: 0 = initial approx, 1 = regc, 2 = denom
- sel_mux4  output  2  multiplier operand B select: 0 = num, 1 = denom, 2 = rega, 3 = regb
- en_a  output  1  load rega from multiplier
- en_b  output  1  load regb and regc from multiplier
- en_rem  output  1  load remainder register
- busy  output  1  high from the cycle after start is accepted until the DONE cycle (exclusive)
- done  output  1  one-cycle pulse; result and res_op valid
- result  output  32  captured final_ans; holds until next capture
- res_op  output  2  captured op_type

Behaviour:
- Reset (reset=0, asynchronous): state = IDLE, iteration counter = 0, result = 0, res_op = 0.
- All control outputs, busy and done read 0 while reset is low and in IDLE.
- Reset asserted mid-operation aborts immediately; no done pulse is produced.
- Outputs are a Moore decode of the state register only, so they are glitch-free with respect to start.
- State decode (sel_mux3 / sel_mux4 / en_a / en_b / en_rem):
  - IDLE: 0/0/0/0/0
  - INIT_A: 0/0/1/0/0
  - INIT_B: 0/1/0/1/0
  - ITER_A: 1/2/1/0/0
  - ITER_B: 1/3/0/1/0
  - REM: 2/2/0/0/1
  - CAPTURE: 0/0/0/0/0
  - DONE: 0/0/0/0/0
- ITER_A must precede ITER_B within an iteration: both products consume the old regc, and regc updates only on en_b.
- Transitions:
  - IDLE -> INIT_A when start=1.
  - INIT_A -> INIT_B.
  - INIT_B -> ITER_A if ITERS>0, else -> REM.
  - ITER_A -> ITER_B.
  - ITER_B -> ITER_A if count < ITERS-1, else -> REM. Count increments on each ITER_B and clears on INIT_A.
  - REM -> CAPTURE.
  - CAPTURE -> DONE. result <= final_ans and res_op <= op_type at the end of CAPTURE; the remainder is valid combinationally after REM.
  - DONE -> INIT_A if start=1 (back-to-back), else -> IDLE.
- busy = 1 in INIT_A through CAPTURE. done = 1 only in DONE.
- start in any state other than IDLE/DONE is ignored (not queued).
- Latency: with start sampled high at edge 0, done is high during cycle 2*ITERS+5 after that edge (11 cycles for ITERS=3, 5 cycles for ITERS=0).
- Throughput with continuous start: one result every 2*ITERS+5 cycles.
- Counter width is 3 bits; it never wraps for legal ITERS.
- result and res_op change only at the end of CAPTURE.

Test Plan:
- Reset check: reset=0 with start=1 -> all outputs 0. Release reset with start=0 -> outputs stay 0, state IDLE.
- Single divide, ITERS=3: one-cycle start pulse, datapath stub drives final_ans=32'h3F400000 and op_type=2'd1 -> exact per-cycle sequence INIT_A, INIT_B, 3×(ITER_A, ITER_B), REM, CAPTURE. en_a high 4 cycles, en_b high 4 cycles, en_rem high 1 cycle. done high exactly at cycle 11; result=32'h3F400000, res_op=1.
- Ignored start: start held high continuously through the operation -> only one op is in flight. DONE re-enters INIT_A, so done repeats every 11 cycles and busy drops only during the DONE cycle.
- ITERS=0 build: start pulse -> INIT_A, INIT_B, REM, CAPTURE, DONE. done at cycle 5; no cycle with sel_mux4=3.
- Reset mid-op: assert reset during the second ITER_B -> outputs go 0 asynchronously with no done pulse. The next start runs the full 11-cycle sequence and the counter restarts from 0.
- Result hold: two back-to-back divides with final_ans 32'h40000000 then 32'hBF800000 -> result changes only at the end of each CAPTURE and holds 32'hBF800000 indefinitely afterward.
